// File: rtl/rep_flit_fifo_pkg.sv
// Shared definitions for the reply flit FIFO: flit framing codes, default widths, message limits.
// Pure types and constants; no latency or backpressure behaviour of its own.
package rep_flit_fifo_pkg;

  localparam int FLIT_W        = 16;
  localparam int CTRL_W        = 2;
  localparam int MAX_MSG_FLITS = 11;

  typedef enum logic [CTRL_W-1:0] {
    CTRL_NONE = 2'b00,
    CTRL_HEAD = 2'b01,
    CTRL_BODY = 2'b10,
    CTRL_TAIL = 2'b11
  } ctrl_e;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_PKT  = 1'b1
  } in_state_e;

  function automatic logic is_tail(input logic [CTRL_W-1:0] ctrl);
    return ctrl == CTRL_TAIL;
  endfunction

endpackage

// File: rtl/flit_fifo_ram.sv
// DEPTH x W storage, one synchronous write port and an asynchronous read port.
// Write lands on the clock edge; read data follows the address combinationally; no flow control.
module flit_fifo_ram #(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents are never reset; the controller masks entries that hold no live flit.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rep_flit_fifo.sv
// Reply flit FIFO between directory upload stage and ring: first-word fall-through, 1-cycle write-to-output.
// rep_fifo_rdy is registered-only (occupancy < DEPTH); output holds until ring_rdy; framing errors are sticky.
module rep_flit_fifo #(
  parameter int FLIT_W = rep_flit_fifo_pkg::FLIT_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] dc_flit_out,
  input  logic              v_dc_flit_out,
  input  logic [1:0]        dc_ctrl_out,
  output logic              rep_fifo_rdy,
  output logic [FLIT_W-1:0] rep_flit_out,
  output logic              v_rep_flit_out,
  output logic [1:0]        rep_ctrl_out,
  input  logic              ring_rdy,
  output logic [CNT_W-1:0]  rep_pkt_cnt,
  output logic              rep_fifo_err
);

  import rep_flit_fifo_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = CTRL_W + FLIT_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  in_state_e        state_q;
  logic             err_q;

  logic             wr_en;
  logic             rd_en;
  logic             wr_tail;
  logic             rd_tail;
  logic [ENT_W-1:0] wr_ent;
  logic [ENT_W-1:0] rd_ent;
  logic [CTRL_W-1:0] rd_ctrl;
  logic [FLIT_W-1:0] rd_flit;

  assign rep_fifo_rdy   = occ_q < DEPTH_C;
  assign v_rep_flit_out = occ_q != '0;

  assign wr_en  = v_dc_flit_out & rep_fifo_rdy;
  assign rd_en  = v_rep_flit_out & ring_rdy;
  assign wr_ent = {dc_ctrl_out, dc_flit_out};

  assign rd_ctrl = rd_ent[ENT_W-1:FLIT_W];
  assign rd_flit = rd_ent[FLIT_W-1:0];
  assign wr_tail = is_tail(dc_ctrl_out);
  assign rd_tail = is_tail(rd_ctrl);

  flit_fifo_ram #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_ent),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_ent)
  );

  // An empty queue shows zeros so stale array words never reach the ring.
  assign rep_flit_out = v_rep_flit_out ? rd_flit : '0;
  assign rep_ctrl_out = v_rep_flit_out ? rd_ctrl : '0;
  assign rep_pkt_cnt  = pkt_q;
  assign rep_fifo_err = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case ({wr_en & wr_tail, rd_en & rd_tail})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
    end
  end

  // Framing checker sees accepted writes only; offending flits are still stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IN_IDLE;
      err_q   <= 1'b0;
    end else begin
      if (v_dc_flit_out && !rep_fifo_rdy) begin
        err_q <= 1'b1;
      end
      if (wr_en) begin
        case (state_q)
          IN_IDLE: begin
            case (dc_ctrl_out)
              CTRL_HEAD: state_q <= IN_PKT;
              CTRL_TAIL: state_q <= IN_IDLE;
              default:   err_q   <= 1'b1;
            endcase
          end
          IN_PKT: begin
            case (dc_ctrl_out)
              CTRL_BODY: state_q <= IN_PKT;
              CTRL_TAIL: state_q <= IN_IDLE;
              default:   err_q   <= 1'b1;
            endcase
          end
          default: state_q <= IN_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rep_flit_fifo.sv
// Directed bench for rep_flit_fifo with a queue scoreboard and a small framing model.
module tb_rep_flit_fifo;

  import rep_flit_fifo_pkg::*;

  localparam int TB_DEPTH = 16;
  localparam int MSG_LEN  = MAX_MSG_FLITS - 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dc_flit_out;
  logic        v_dc_flit_out;
  logic [1:0]  dc_ctrl_out;
  logic        rep_fifo_rdy;
  logic [15:0] rep_flit_out;
  logic        v_rep_flit_out;
  logic [1:0]  rep_ctrl_out;
  logic        ring_rdy;
  logic [4:0]  rep_pkt_cnt;
  logic        rep_fifo_err;

  int vectors    = 0;
  int miscompares = 0;

  logic [17:0] sb[$];
  int          exp_pkt = 0;
  bit          exp_err = 1'b0;
  bit          m_inpkt = 1'b0;

  always #5 clk = ~clk;

  rep_flit_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .dc_flit_out    (dc_flit_out),
    .v_dc_flit_out  (v_dc_flit_out),
    .dc_ctrl_out    (dc_ctrl_out),
    .rep_fifo_rdy   (rep_fifo_rdy),
    .rep_flit_out   (rep_flit_out),
    .v_rep_flit_out (v_rep_flit_out),
    .rep_ctrl_out   (rep_ctrl_out),
    .ring_rdy       (ring_rdy),
    .rep_pkt_cnt    (rep_pkt_cnt),
    .rep_fifo_err   (rep_fifo_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the head before the edge, update the model, check state after it.
  task automatic cycle();
    bit rd;
    bit wr;
    logic [17:0] front;
    if (rst) begin
      @(posedge clk);
      #1;
      sb.delete();
      exp_pkt = 0;
      exp_err = 1'b0;
      m_inpkt = 1'b0;
      chk("rst_v", {31'd0, v_rep_flit_out}, 0);
      chk("rst_rdy", {31'd0, rep_fifo_rdy}, 1);
      chk("rst_pkt", {27'd0, rep_pkt_cnt}, 0);
      chk("rst_err", {31'd0, rep_fifo_err}, 0);
      chk("rst_flit", {16'd0, rep_flit_out}, 0);
      chk("rst_ctrl", {30'd0, rep_ctrl_out}, 0);
      return;
    end
    rd = 1'b0;
    front = '0;
    if (sb.size() != 0) begin
      front = sb[0];
      chk("head_v", {31'd0, v_rep_flit_out}, 1);
      chk("head_flit", {16'd0, rep_flit_out}, {16'd0, front[15:0]});
      chk("head_ctrl", {30'd0, rep_ctrl_out}, {30'd0, front[17:16]});
      rd = ring_rdy;
    end else begin
      chk("empty_v", {31'd0, v_rep_flit_out}, 0);
    end
    wr = v_dc_flit_out && (sb.size() < TB_DEPTH);
    if (v_dc_flit_out && !wr) exp_err = 1'b1;
    if (wr) begin
      if (!m_inpkt) begin
        if (dc_ctrl_out == 2'b01) m_inpkt = 1'b1;
        else if (dc_ctrl_out != 2'b11) exp_err = 1'b1;
      end else begin
        if (dc_ctrl_out == 2'b11) m_inpkt = 1'b0;
        else if (dc_ctrl_out != 2'b10) exp_err = 1'b1;
      end
    end
    if (rd) begin
      void'(sb.pop_front());
      if (front[17:16] == 2'b11) exp_pkt--;
    end
    if (wr) begin
      sb.push_back({dc_ctrl_out, dc_flit_out});
      if (dc_ctrl_out == 2'b11) exp_pkt++;
    end
    @(posedge clk);
    #1;
    chk("v_out", {31'd0, v_rep_flit_out}, {31'd0, sb.size() != 0});
    chk("fifo_rdy", {31'd0, rep_fifo_rdy}, {31'd0, sb.size() < TB_DEPTH});
    chk("pkt_cnt", {27'd0, rep_pkt_cnt}, exp_pkt);
    chk("fifo_err", {31'd0, rep_fifo_err}, {31'd0, exp_err});
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] d);
    v_dc_flit_out = 1'b1;
    dc_ctrl_out   = c;
    dc_flit_out   = d;
    cycle();
    v_dc_flit_out = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    v_dc_flit_out = 1'b0;
    dc_ctrl_out = 2'b00;
    dc_flit_out = 16'h0;
    ring_rdy = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;

    // Single-flit message straight through.
    ring_rdy = 1'b1;
    send(2'b11, 16'h2001);
    cycle();

    // Nine-flit message held back, then released.
    ring_rdy = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (i == 0) send(2'b01, 16'hcade);
      else if (i == MSG_LEN - 1) send(2'b11, 16'hc0de);
      else send(2'b10, 16'hc0de + 16'(i * 256));
    end
    chk("occ_msg", {27'd0, dut.occ_q}, MSG_LEN);
    ring_rdy = 1'b1;
    repeat (MSG_LEN + 1) cycle();

    // Fill to full, overflow, then one read reopens space.
    ring_rdy = 1'b0;
    for (int i = 0; i < TB_DEPTH; i++) begin
      if (i == 0) send(2'b01, 16'h1000);
      else if (i == TB_DEPTH - 1) send(2'b11, 16'h1000 + 16'(i));
      else send(2'b10, 16'h1000 + 16'(i));
    end
    chk("full_rdy", {31'd0, rep_fifo_rdy}, 0);
    send(2'b01, 16'hdead);
    ring_rdy = 1'b1;
    cycle();
    chk("reopen_rdy", {31'd0, rep_fifo_rdy}, 1);
    repeat (TB_DEPTH) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Steady occupancy of 8 with concurrent read/write across pointer wrap.
    ring_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send(2'b11, 16'h5000 + 16'(i));
    ring_rdy = 1'b1;
    v_dc_flit_out = 1'b1;
    dc_ctrl_out = 2'b11;
    for (int i = 0; i < 40; i++) begin
      dc_flit_out = 16'h5008 + 16'(i);
      cycle();
      chk("occ_steady", {27'd0, dut.occ_q}, 8);
    end
    v_dc_flit_out = 1'b0;
    repeat (9) cycle();

    // Body flit while idle: sticky error, flit still delivered.
    ring_rdy = 1'b0;
    send(2'b10, 16'h7777);
    send(2'b11, 16'h7778);
    ring_rdy = 1'b1;
    repeat (5) cycle();
    chk("err_sticky", {31'd0, rep_fifo_err}, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Reset in the middle of a message, then a clean single flit.
    ring_rdy = 1'b0;
    send(2'b01, 16'h4000);
    for (int i = 1; i <= 3; i++) send(2'b10, 16'h4000 + 16'(i));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ring_rdy = 1'b1;
    send(2'b11, 16'h3001);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
